multicycle_sequencer: RTL and testbench

//  Multi-cycle FSM that steps the 18-bit CPU datapath through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/multicycle_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 18-bit CPU datapath (FETCH/DECODE/EXEC/MEM/WB).
// Ports: clk, reset (async active-low), opcode/zf/cf/mem_ack in; memory, datapath strobes, state, bus_err out.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       zf,
    input  logic       cf,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic [2:0] alu_op,
    output logic       alu_src,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       flag_write,
    output logic [2:0] state,
    output logic       bus_err
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_ANDI = 4'h4;
    localparam logic [3:0] OP_NAND = 4'h5;
    localparam logic [3:0] OP_NOR  = 4'h6;
    localparam logic [3:0] OP_JUMP = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_CMP  = 4'hA;
    localparam logic [3:0] OP_JE   = 4'hB;
    localparam logic [3:0] OP_JA   = 4'hC;
    localparam logic [3:0] OP_JB   = 4'hD;
    localparam logic [3:0] OP_JAE  = 4'hE;
    localparam logic [3:0] OP_JBE  = 4'hF;

    // Last unacknowledged request cycle before the bus is declared dead.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0] st_q;
    logic [2:0] st_d;
    logic [3:0] op_q;
    logic [7:0] cnt_q;

    logic       is_alu;
    logic       is_ldst;
    logic       is_jmp;
    logic       taken;
    logic       imm;
    logic [2:0] aop;
    logic       tmo;

    logic       req_c;
    logic       we_c;
    logic       sel_c;
    logic       irw_c;
    logic       pcw_c;
    logic       pcs_c;
    logic [2:0] aop_c;
    logic       asrc_c;
    logic       rw_c;
    logic       m2r_c;
    logic       fw_c;
    logic       err_c;

    // Instruction class decode of the latched opcode.
    always_comb begin
        is_alu  = 1'b0;
        is_ldst = 1'b0;
        is_jmp  = 1'b0;
        taken   = 1'b0;
        imm     = 1'b0;
        aop     = 3'b000;
        unique case (1'b1)
            (op_q == OP_ADD):  begin is_alu = 1'b1; aop = 3'b000; end
            (op_q == OP_ADDI): begin is_alu = 1'b1; aop = 3'b101; imm = 1'b1; end
            (op_q == OP_AND):  begin is_alu = 1'b1; aop = 3'b001; end
            (op_q == OP_ANDI): begin is_alu = 1'b1; aop = 3'b110; imm = 1'b1; end
            (op_q == OP_NAND): begin is_alu = 1'b1; aop = 3'b010; end
            (op_q == OP_NOR):  begin is_alu = 1'b1; aop = 3'b011; end
            (op_q == OP_LD),
            (op_q == OP_ST):   begin is_ldst = 1'b1; imm = 1'b1; end
            (op_q == OP_JUMP): begin is_jmp = 1'b1; taken = 1'b1; end
            (op_q == OP_JE):   begin is_jmp = 1'b1; taken = zf; end
            (op_q == OP_JA):   begin is_jmp = 1'b1; taken = !zf && !cf; end
            (op_q == OP_JB):   begin is_jmp = 1'b1; taken = !zf && cf; end
            (op_q == OP_JAE):  begin is_jmp = 1'b1; taken = !cf; end
            (op_q == OP_JBE):  begin is_jmp = 1'b1; taken = zf || cf; end
            default: ;
        endcase
    end

    // Fires on the MEM_TIMEOUT-th consecutive request cycle without ack.
    assign tmo = !mem_ack && (cnt_q == TMO_LAST);

    always_comb begin
        st_d   = st_q;
        req_c  = 1'b0;
        we_c   = 1'b0;
        sel_c  = 1'b0;
        irw_c  = 1'b0;
        pcw_c  = 1'b0;
        pcs_c  = 1'b0;
        aop_c  = 3'b000;
        asrc_c = 1'b0;
        rw_c   = 1'b0;
        m2r_c  = 1'b0;
        fw_c   = 1'b0;
        err_c  = 1'b0;
        case (st_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_ack) begin
                    irw_c = 1'b1;
                    st_d  = S_DECODE;
                end else if (tmo) begin
                    st_d = S_ERR;
                end
            end
            S_DECODE: begin
                // NOP retires here, before op_q holds it.
                if (opcode == OP_NOP) begin
                    pcw_c = 1'b1;
                    st_d  = S_FETCH;
                end else begin
                    st_d = S_EXEC;
                end
            end
            S_EXEC: begin
                st_d = S_FETCH;
                if (is_alu) begin
                    aop_c  = aop;
                    asrc_c = imm;
                    st_d   = S_WB;
                end else if (op_q == OP_CMP) begin
                    aop_c = 3'b100;
                    fw_c  = 1'b1;
                    pcw_c = 1'b1;
                end else if (is_ldst) begin
                    asrc_c = 1'b1;
                    st_d   = S_MEM;
                end else if (is_jmp) begin
                    pcw_c = 1'b1;
                    pcs_c = taken;
                end
            end
            S_MEM: begin
                req_c  = 1'b1;
                sel_c  = 1'b1;
                asrc_c = 1'b1;
                we_c   = (op_q == OP_ST);
                if (mem_ack) begin
                    if (op_q == OP_ST) begin
                        pcw_c = 1'b1;
                        st_d  = S_FETCH;
                    end else begin
                        st_d = S_WB;
                    end
                end else if (tmo) begin
                    st_d = S_ERR;
                end
            end
            S_WB: begin
                rw_c   = 1'b1;
                m2r_c  = (op_q == OP_LD);
                aop_c  = aop;
                asrc_c = imm;
                pcw_c  = 1'b1;
                st_d   = S_FETCH;
            end
            S_ERR: begin
                err_c = 1'b1;
            end
            default: st_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q  <= S_FETCH;
            op_q  <= OP_NOP;
            cnt_q <= 8'd0;
        end else begin
            st_q <= st_d;
            if (st_q == S_DECODE) begin
                op_q <= opcode;
            end
            // Leaving FETCH/MEM or getting an ack restarts the wait count.
            if (req_c && !mem_ack) begin
                cnt_q <= cnt_q + 8'd1;
            end else begin
                cnt_q <= 8'd0;
            end
        end
    end

    // Every output is held low while reset is asserted, with no clock needed.
    assign mem_req      = reset & req_c;
    assign mem_we       = reset & we_c;
    assign mem_addr_sel = reset & sel_c;
    assign ir_write     = reset & irw_c;
    assign pc_write     = reset & pcw_c;
    assign pc_src       = reset & pcs_c;
    assign alu_op       = reset ? aop_c : 3'b000;
    assign alu_src      = reset & asrc_c;
    assign reg_write    = reset & rw_c;
    assign mem_to_reg   = reset & m2r_c;
    assign flag_write   = reset & fw_c;
    assign state        = reset ? st_q : 3'b000;
    assign bus_err      = reset & err_c;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized self-checking bench for multicycle_sequencer.
// A per-instruction cycle-trace model predicts every output on every cycle.
module tb_multicycle_sequencer;

    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic       zf;
    logic       cf;
    logic       mem_ack;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       flag_write;
    logic [2:0] state;
    logic       bus_err;

    int checks = 0;
    int errors = 0;

    multicycle_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .zf           (zf),
        .cf           (cf),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .alu_op       (alu_op),
        .alu_src      (alu_src),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .flag_write   (flag_write),
        .state        (state),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] F = 3'd0;
    localparam logic [2:0] D = 3'd1;
    localparam logic [2:0] E = 3'd2;
    localparam logic [2:0] M = 3'd3;
    localparam logic [2:0] W = 3'd4;
    localparam logic [2:0] X = 3'd7;

    logic [16:0] outv;
    assign outv = {state, bus_err, mem_req, mem_we, mem_addr_sel, ir_write,
                   pc_write, pc_src, alu_op, alu_src, reg_write, mem_to_reg,
                   flag_write};

    typedef struct packed {
        logic        ack;
        logic [16:0] exp;
    } cyc_t;

    cyc_t q[$];

    task automatic chk(input string tag, input logic [16:0] got,
                       input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] mk(
        input logic [2:0] st, input logic req, input logic we,
        input logic sel, input logic irw, input logic pcw, input logic pcs,
        input logic [2:0] aop, input logic asrc, input logic rw,
        input logic m2r, input logic fw);
        return {st, (st == X), req, we, sel, irw, pcw, pcs, aop, asrc, rw,
                m2r, fw};
    endfunction

    function automatic logic [2:0] ref_aop(input logic [3:0] op);
        case (op)
            4'h2: return 3'b101;
            4'h3: return 3'b001;
            4'h4: return 3'b110;
            4'h5: return 3'b010;
            4'h6: return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [3:0] op,
                                       input logic z, input logic c);
        case (op)
            4'h7: return 1'b1;
            4'hB: return z;
            4'hC: return !z && !c;
            4'hD: return !z && c;
            4'hE: return !c;
            4'hF: return z || c;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Builds the expected cycle trace of one instruction.
    task automatic gen(input logic [3:0] op, input logic z, input logic c,
                       input int fw, input int mw);
        logic imm;
        logic [2:0] a;
        imm = (op == 4'h2) || (op == 4'h4);
        a = ref_aop(op);
        for (int i = 0; i < fw; i++)
            q.push_back('{1'b0, mk(F,1,0,0,0,0,0,3'b000,0,0,0,0)});
        q.push_back('{1'b1, mk(F,1,0,0,1,0,0,3'b000,0,0,0,0)});
        if (op == 4'h0) begin
            q.push_back('{rnd(), mk(D,0,0,0,0,1,0,3'b000,0,0,0,0)});
            return;
        end
        q.push_back('{rnd(), mk(D,0,0,0,0,0,0,3'b000,0,0,0,0)});
        if (op >= 4'h1 && op <= 4'h6) begin
            q.push_back('{rnd(), mk(E,0,0,0,0,0,0,a,imm,0,0,0)});
            q.push_back('{rnd(), mk(W,0,0,0,0,1,0,a,imm,1,0,0)});
        end else if (op == 4'hA) begin
            q.push_back('{rnd(), mk(E,0,0,0,0,1,0,3'b100,0,0,0,1)});
        end else if (op == 4'h8 || op == 4'h9) begin
            logic st;
            st = (op == 4'h9);
            q.push_back('{rnd(), mk(E,0,0,0,0,0,0,3'b000,1,0,0,0)});
            for (int i = 0; i < mw; i++)
                q.push_back('{1'b0, mk(M,1,st,1,0,0,0,3'b000,1,0,0,0)});
            q.push_back('{1'b1, mk(M,1,st,1,0,st,0,3'b000,1,0,0,0)});
            if (!st)
                q.push_back('{rnd(), mk(W,0,0,0,0,1,0,3'b000,1,1,1,0)});
        end else begin
            q.push_back('{rnd(), mk(E,0,0,0,0,1,ref_taken(op, z, c),
                                    3'b000,0,0,0,0)});
        end
    endtask

    task automatic step(input string tag, input logic ack,
                        input logic [16:0] exp);
        mem_ack = ack;
        @(negedge clk);
        chk(tag, outv, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [3:0] op,
                       input logic z, input logic c, input int fw,
                       input int mw);
        cyc_t e;
        opcode = op;
        zf = z;
        cf = c;
        gen(op, z, c, fw, mw);
        while (q.size() > 0) begin
            e = q.pop_front();
            step(tag, e.ack, e.exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("reset_out", outv, 17'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic [16:0] fetch_v;
    logic [16:0] err_v;

    initial begin
        reset = 1'b0;
        opcode = 4'h0;
        zf = 1'b0;
        cf = 1'b0;
        mem_ack = 1'b0;
        fetch_v = mk(F,1,0,0,0,0,0,3'b000,0,0,0,0);
        err_v = mk(X,0,0,0,0,0,0,3'b000,0,0,0,0);
        repeat (2) @(posedge clk);
        chk("reset_hold", outv, 17'd0);
        #1;
        reset = 1'b1;

        run("add",    4'h1, 0, 0, 0, 0);
        run("ld_w3",  4'h8, 0, 0, 0, 3);
        run("jbe",    4'hF, 0, 1, 0, 0);
        run("ja",     4'hC, 0, 1, 0, 0);
        run("je",     4'hB, 1, 0, 0, 0);
        run("cmp",    4'hA, 0, 0, 0, 0);
        run("nop",    4'h0, 0, 0, 1, 0);
        run("st",     4'h9, 0, 0, 2, 1);
        run("fetch14",4'h2, 0, 0, 14, 0);
        run("mem14",  4'h8, 0, 0, 0, 14);

        for (int n = 0; n < 60; n++) begin
            logic [3:0] op;
            int fw;
            int mw;
            op = 4'($urandom_range(0, 15));
            fw = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
            run("rand", op, rnd(), rnd(), fw, mw);
        end

        for (int i = 0; i < 15; i++) step("fetch_tmo", 1'b0, fetch_v);
        for (int i = 0; i < 4; i++) step("err_sticky", rnd(), err_v);
        do_reset();
        step("post_err", 1'b0, fetch_v);

        opcode = 4'h8;
        step("ld_tmo_f", 1'b1, mk(F,1,0,0,1,0,0,3'b000,0,0,0,0));
        step("ld_tmo_d", 1'b0, mk(D,0,0,0,0,0,0,3'b000,0,0,0,0));
        step("ld_tmo_e", 1'b0, mk(E,0,0,0,0,0,0,3'b000,1,0,0,0));
        for (int i = 0; i < 15; i++)
            step("mem_tmo", 1'b0, mk(M,1,0,1,0,0,0,3'b000,1,0,0,0));
        step("mem_err", 1'b1, err_v);
        do_reset();

        opcode = 4'h9;
        step("st_f", 1'b1, mk(F,1,0,0,1,0,0,3'b000,0,0,0,0));
        step("st_d", 1'b0, mk(D,0,0,0,0,0,0,3'b000,0,0,0,0));
        step("st_e", 1'b0, mk(E,0,0,0,0,0,0,3'b000,1,0,0,0));
        mem_ack = 1'b0;
        @(negedge clk);
        chk("st_mem", outv, mk(M,1,1,1,0,0,0,3'b000,1,0,0,0));
        #2;
        reset = 1'b0;
        #1;
        chk("st_async_drop", {15'd0, mem_req, mem_we}, 17'd0);
        chk("st_async_state", {14'd0, state}, 17'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("st_release", outv, fetch_v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
